// File: rtl/tm_sch_event_arb.sv
// Weighted round-robin arbiter for scheduler event FIFOs.
// Selects one show-ahead event FIFO at a time. A granted queue may then keep
// popping up to its weight in consecutive cycles before round-robin moves on.
// The popped event is presented downstream through a one-entry output register.
`ifndef FIRST_LVL_SCH_ID_NBITS
`define FIRST_LVL_SCH_ID_NBITS 8
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tm_sch_event_arb #(
    parameter int NUM_Q        = 4,
    parameter int WIDTH        = `FIRST_LVL_SCH_ID_NBITS,
    parameter int WEIGHT_NBITS = 4,
    localparam int QID_W       = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
    input  logic                          clk,
    input  logic                          `RESET_SIG,
    input  logic [NUM_Q-1:0]              q_empty,
    input  logic [NUM_Q*WIDTH-1:0]        q_data,
    output logic [NUM_Q-1:0]              q_pop,
    input  logic [NUM_Q*WEIGHT_NBITS-1:0] cfg_weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [QID_W-1:0]              out_qid,
    output logic                          arb_idle
);

    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t                  state;
    logic [QID_W-1:0]        cur_q;
    logic [WEIGHT_NBITS-1:0] burst_cnt;
    logic [QID_W-1:0]        rr_ptr;

    logic [NUM_Q-1:0]        elig;
    logic                    can_issue;
    logic                    found;
    logic [QID_W-1:0]        sel;
    logic [WEIGHT_NBITS-1:0] sel_w;
    logic [WEIGHT_NBITS-1:0] cur_w;
    logic [WEIGHT_NBITS:0]   burst_inc;
    logic                    burst_done;
    logic                    pop_en;
    logic [QID_W-1:0]        pop_q;
    logic                    idle_nxt;
    logic                    valid_nxt;

    // Successor queue index with explicit wrap, valid for any NUM_Q.
    function automatic logic [QID_W-1:0] next_q(input logic [QID_W-1:0] q);
        if (int'(q) >= NUM_Q - 1) return '0;
        return q + 1'b1;
    endfunction

    // Per-queue eligibility: has an event and is not disabled by a zero weight.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            elig[i] = ~q_empty[i] & (cfg_weight[i*WEIGHT_NBITS +: WEIGHT_NBITS] != '0);
        end
    end

    // Round-robin search for the first eligible queue starting at rr_ptr.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_Q;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = QID_W'(idx);
            end
        end
    end

    // Pop decision; weights are re-read every cycle so a lowered weight
    // terminates the burst at the next pop (>= rather than ==).
    always_comb begin
        can_issue  = ~out_valid | out_ready;
        sel_w      = cfg_weight[int'(sel)*WEIGHT_NBITS +: WEIGHT_NBITS];
        cur_w      = cfg_weight[int'(cur_q)*WEIGHT_NBITS +: WEIGHT_NBITS];
        burst_inc  = {1'b0, burst_cnt} + 1'b1;
        burst_done = (burst_inc >= {1'b0, cur_w});
        pop_en     = 1'b0;
        pop_q      = sel;
        if (!`RESET_SIG) begin
            if (state == IDLE) begin
                pop_en = found & can_issue;
                pop_q  = sel;
            end else begin
                pop_en = elig[cur_q] & can_issue;
                pop_q  = cur_q;
            end
        end
        q_pop     = pop_en ? (NUM_Q'(1) << pop_q) : '0;
        valid_nxt = pop_en | (out_valid & ~out_ready);
        if (state == IDLE) begin
            idle_nxt = ~(pop_en && (sel_w != WEIGHT_NBITS'(1)));
        end else begin
            idle_nxt = ~elig[cur_q] | (pop_en & burst_done);
        end
        idle_nxt = idle_nxt & ~valid_nxt;
    end

    // Arbitration FSM: IDLE picks a queue, SERVE continues its burst.
    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            state     <= IDLE;
            cur_q     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            arb_idle  <= 1'b1;
        end else begin
            arb_idle <= idle_nxt;
            case (state)
                IDLE: begin
                    if (pop_en) begin
                        cur_q     <= sel;
                        burst_cnt <= WEIGHT_NBITS'(1);
                        if (sel_w == WEIGHT_NBITS'(1)) rr_ptr <= next_q(sel);
                        else                           state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (!elig[cur_q]) begin
                        state  <= IDLE;
                        rr_ptr <= next_q(cur_q);
                    end else if (pop_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_done) begin
                            state  <= IDLE;
                            rr_ptr <= next_q(cur_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on pop, drain on accept, hold while stalled.
    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else if (pop_en) begin
            out_valid <= 1'b1;
            out_data  <= q_data[int'(pop_q)*WIDTH +: WIDTH];
            out_qid   <= pop_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tm_sch_event_arb.sv
// Bench for tm_sch_event_arb: reset/selection vector table, directed burst
// sequences, and randomized traffic against a behavioural arbiter model.
`ifndef FIRST_LVL_SCH_ID_NBITS
`define FIRST_LVL_SCH_ID_NBITS 8
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_tm_sch_event_arb;
    localparam int NQ  = 4;
    localparam int W   = `FIRST_LVL_SCH_ID_NBITS;
    localparam int WB  = 4;
    localparam int QW  = 2;
    localparam int CAP = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NQ-1:0]     q_empty = '1;
    logic [NQ*W-1:0]   q_data = '0;
    logic [NQ-1:0]     q_pop;
    logic [NQ*WB-1:0]  cfg_weight = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic [QW-1:0]     out_qid;
    logic              arb_idle;

    tm_sch_event_arb #(.NUM_Q(NQ), .WIDTH(W), .WEIGHT_NBITS(WB)) dut (
        .clk(clk), .`RESET_SIG(rst), .q_empty(q_empty), .q_data(q_data),
        .q_pop(q_pop), .cfg_weight(cfg_weight), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_qid(out_qid),
        .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // event FIFO models
    logic [W-1:0] fmem [NQ][CAP];
    int fhd [NQ];
    int fcnt[NQ];
    int wgt [NQ];

    // behavioural arbiter model
    bit           m_serv  = 0;
    int           m_cur   = 0;
    int           m_cnt   = 0;
    int           m_ptr   = 0;
    bit           m_valid = 0;
    logic [W-1:0] m_data  = '0;
    int           m_qid   = 0;

    logic [W-1:0] sb_d[$];
    int           sb_q[$];
    int           dut_idx;

    typedef struct {
        logic [NQ-1:0]    emp;
        logic [NQ*WB-1:0] w;
        logic [NQ-1:0]    exp_pop;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NQ-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NQ; i++) if (v[i]) begin r = i; n++; end
        if (n > 1) r = -2;
        return r;
    endfunction

    function automatic bit elig(input int q);
        return (fcnt[q] > 0) && (wgt[q] != 0);
    endfunction

    task automatic fpush(input int q, input logic [W-1:0] d);
        fmem[q][(fhd[q] + fcnt[q]) % CAP] = d;
        fcnt[q]++;
    endtask

    task automatic fclear();
        for (int i = 0; i < NQ; i++) begin fhd[i] = 0; fcnt[i] = 0; end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]            = (fcnt[i] == 0);
            q_data[i*W +: W]      = fmem[i][fhd[i]];
            cfg_weight[i*WB +: WB] = WB'(wgt[i]);
        end
    endtask

    // Which queue should be popped this cycle according to the arbitration rules.
    function automatic int model_pick();
        bit can;
        if (rst) return -1;
        can = !m_valid || out_ready;
        if (!can) return -1;
        if (!m_serv) begin
            for (int k = 0; k < NQ; k++)
                if (elig((m_ptr + k) % NQ)) return (m_ptr + k) % NQ;
            return -1;
        end
        return elig(m_cur) ? m_cur : -1;
    endfunction

    task automatic model_update(input int p);
        if (rst) begin
            m_serv = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
            m_valid = 0; m_data = '0; m_qid = 0;
            return;
        end
        if (!m_serv) begin
            if (p >= 0) begin
                m_cur = p; m_cnt = 1;
                if (m_cnt >= wgt[p]) m_ptr = (p + 1) % NQ;
                else m_serv = 1;
            end
        end else if (!elig(m_cur)) begin
            m_serv = 0; m_ptr = (m_cur + 1) % NQ;
        end else if (p >= 0) begin
            m_cnt++;
            if (m_cnt >= wgt[m_cur]) begin m_serv = 0; m_ptr = (m_cur + 1) % NQ; end
        end
        if (p >= 0) begin
            m_valid = 1; m_data = fmem[p][fhd[p]]; m_qid = p;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        int ep;
        drive_inputs();
        #1;
        ep = model_pick();
        dut_idx = oh_idx(q_pop);
        chk("q_pop", 32'(q_pop), (ep >= 0) ? (32'd1 << ep) : 32'd0);
        if (rst) begin
            sb_d.delete(); sb_q.delete();
        end else if (out_valid && out_ready) begin
            if (sb_d.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                chk("sb_data", 32'(out_data), 32'(sb_d.pop_front()));
                chk("sb_qid", 32'(out_qid), 32'(sb_q.pop_front()));
            end
        end
        if (ep >= 0) begin
            sb_d.push_back(fmem[ep][fhd[ep]]);
            sb_q.push_back(ep);
        end
        model_update(ep);
        @(posedge clk);
        #1;
        if (ep >= 0) begin
            fhd[ep] = (fhd[ep] + 1) % CAP;
            fcnt[ep]--;
        end
        drive_inputs();
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_qid", 32'(out_qid), 32'(m_qid));
        chk("arb_idle", 32'(arb_idle), 32'(!m_serv && !m_valid));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load_all(input int n);
        for (int i = 0; i < NQ; i++)
            for (int j = 0; j < n; j++) fpush(i, W'($urandom));
    endtask

    int exp32[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp33[12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    int exp34[5]  = '{0, 0, -1, 1, 1};

    initial begin
        logic [W-1:0] held;
        int qi;
        fclear();
        for (int i = 0; i < NQ; i++) wgt[i] = 1;

        tbl[0] = '{4'b0000, 16'h1111, 4'b0001};
        tbl[1] = '{4'b0001, 16'h1111, 4'b0010};
        tbl[2] = '{4'b1111, 16'h1111, 4'b0000};
        tbl[3] = '{4'b0000, 16'h1110, 4'b0010};
        tbl[4] = '{4'b0000, 16'h0000, 4'b0000};
        tbl[5] = '{4'b0011, 16'h1011, 4'b1000};
        tbl[6] = '{4'b0111, 16'h2000, 4'b1000};

        @(negedge clk);

        // reset state and first selection from rr_ptr=0
        for (int r = 0; r < 7; r++) begin
            rst = 1'b1;
            out_ready = 1'b1;
            q_empty = tbl[r].emp;
            cfg_weight = tbl[r].w;
            for (int i = 0; i < NQ; i++) q_data[i*W +: W] = W'(8'hA0 + i);
            #1;
            chk("tbl_pop_in_reset", 32'(q_pop), 32'd0);
            @(posedge clk); @(negedge clk);
            chk("tbl_rst_valid", 32'(out_valid), 32'd0);
            chk("tbl_rst_idle", 32'(arb_idle), 32'd1);
            chk("tbl_rst_data", 32'(out_data), 32'd0);
            chk("tbl_rst_qid", 32'(out_qid), 32'd0);
            rst = 1'b0;
            #1;
            chk("tbl_pop", 32'(q_pop), 32'(tbl[r].exp_pop));
            @(posedge clk); @(negedge clk);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[r].exp_pop != 0));
            if (tbl[r].exp_pop != 0) begin
                qi = oh_idx(tbl[r].exp_pop);
                chk("tbl_qid", 32'(out_qid), 32'(qi));
                chk("tbl_data", 32'(out_data), 32'(8'hA0 + qi));
            end
        end

        // equal weights: plain round robin
        fclear(); do_reset();
        for (int i = 0; i < NQ; i++) wgt[i] = 1;
        load_all(16);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin step(); chk("seq_rr", 32'(dut_idx), 32'(exp32[k])); end

        // weights {3,1,0,2}
        fclear(); do_reset();
        wgt[0] = 3; wgt[1] = 1; wgt[2] = 0; wgt[3] = 2;
        load_all(16);
        for (int k = 0; k < 12; k++) begin step(); chk("seq_wrr", 32'(dut_idx), 32'(exp33[k])); end

        // burst cut short by an empty queue: one bubble, then rr moves on
        fclear(); do_reset();
        wgt[0] = 4; wgt[1] = 1; wgt[2] = 1; wgt[3] = 1;
        fpush(0, 8'h11); fpush(0, 8'h12);
        fpush(1, 8'h21); fpush(1, 8'h22); fpush(1, 8'h23);
        for (int k = 0; k < 5; k++) begin step(); chk("seq_bubble", 32'(dut_idx), 32'(exp34[k])); end

        // downstream stall for 5 cycles
        fclear(); do_reset();
        for (int i = 0; i < NQ; i++) wgt[i] = 1;
        load_all(4);
        out_ready = 1'b1;
        step(); step();
        held = m_data;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_pop", 32'(dut_idx), 32'hFFFF_FFFF);
            chk("stall_data", 32'(out_data), 32'(held));
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("stall_resume", 32'(dut_idx), 32'd2);

        // reset in the middle of a burst
        fclear(); do_reset();
        wgt[0] = 1; wgt[1] = 4; wgt[2] = 1; wgt[3] = 1;
        load_all(6);
        out_ready = 1'b1;
        step(); step(); step();
        chk("burst_q1", 32'(dut_idx), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_pop", 32'(dut_idx), 32'hFFFF_FFFF);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idle", 32'(arb_idle), 32'd1);
        rst = 1'b0;
        step();
        chk("rst_rrptr0", 32'(dut_idx), 32'd0);

        // randomized traffic, weight changes, stalls and occasional reset
        fclear(); do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0)
                for (int i = 0; i < NQ; i++) wgt[i] = int'($urandom_range(0, 5));
            for (int i = 0; i < NQ; i++)
                if ($urandom_range(0, 3) == 0 && fcnt[i] < CAP - 2) fpush(i, W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NQ; i++) wgt[i] = 0;
        step(); step();
        chk("sb_drained", 32'(sb_d.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
